softex_tcdm_mp_sync: RTL

Sits between the SoftEx wrapper's MP narrow 32-bit TCDM master ports and the cluster TCDM interconnect.
Replaces the naive AND of per-port grants and r_valids with proper per-port grant tracking and per-port response buffering. A wide access is granted upstream only once every narrow port has been granted. It completes upstream only once every narrow port has responded, even when ports are granted and answered in different cycles.

---
 rtl/softex_tcdm_mp_sync.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/softex_tcdm_mp_sync.sv
// Purpose : joins MP narrow 32-bit TCDM ports into one wide access; tracks per-port
//           grants and buffers per-port responses so ports may be served out of step.
// Latency : wide grant is combinational with the last port grant; response is
//           registered, in_r_valid_o rises one cycle after the last port's r_valid.
// Backpr. : at most R_DEPTH wide accesses outstanding (requests held off at the limit);
//           upstream in_r_ready_i low holds the assembled response stable.
// Option  : define SOFTEX_TCDM_MP_SYNC_ERR_EN to add the sticky err_o flag and
//           per-port ID storage for head ID consistency checking.

// Small synchronous FIFO used to buffer one narrow port's responses.
// Head is visible on o_dat whenever o_empty is low; push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module softex_tcdm_mp_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_dat   = r_mem[r_rptr];

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_dat;
    end
  end

  // Pointer and occupancy bookkeeping with wrap at DEPTH-1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

module softex_tcdm_mp_sync #(
  parameter int MP      = 4,
  parameter int IDW     = 8,
  parameter int R_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // wide side (SoftEx wrapper)
  input  logic                in_req_i,
  output logic                in_gnt_o,
  input  logic [MP*32-1:0]    in_add_i,
  input  logic                in_wen_i,
  input  logic [MP*4-1:0]     in_be_i,
  input  logic [MP*32-1:0]    in_data_i,
  input  logic [IDW-1:0]      in_id_i,
  input  logic                in_r_ready_i,
  output logic [MP*32-1:0]    in_r_data_o,
  output logic                in_r_valid_o,
  output logic [IDW-1:0]      in_r_id_o,
  // narrow side (TCDM interconnect)
  output logic [MP-1:0]       out_req_o,
  input  logic [MP-1:0]       out_gnt_i,
  output logic [MP*32-1:0]    out_add_o,
  output logic [MP-1:0]       out_wen_o,
  output logic [MP*4-1:0]     out_be_o,
  output logic [MP*32-1:0]    out_data_o,
  output logic [IDW-1:0]      out_id_o,
  output logic [MP-1:0]       out_r_ready_o,
  input  logic [MP*32-1:0]    out_r_data_i,
  input  logic [MP-1:0]       out_r_valid_i,
  input  logic [MP*IDW-1:0]   out_r_id_i
`ifdef SOFTEX_TCDM_MP_SYNC_ERR_EN
  ,
  output logic                err_o
`endif
);

  // Credit counter spans 0..R_DEPTH. A port may hold one extra pending grant
  // for the wide access still being assembled, hence the wider pending counter.
  localparam int CW = $clog2(R_DEPTH + 1);
  localparam int PW = $clog2(R_DEPTH + 2);

`ifdef SOFTEX_TCDM_MP_SYNC_ERR_EN
  localparam int NID = MP;
`else
  localparam int NID = 1;
`endif

  logic [MP-1:0] r_gnt_q;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_p_cnt [MP];

  logic          w_issue_ok;
  logic [MP-1:0] w_gnt_now;
  logic          w_all_g;
  logic [MP-1:0] w_push;
  logic          w_pop;
  logic          w_all_full;
  logic          w_empty    [MP];
  logic [31:0]   w_head_dat [MP];
  logic [IDW-1:0] w_head_id [NID];

  // ---------------------------------------------------------------------------
  // Payload pass-through; upstream holds it stable until the wide grant.
  // ---------------------------------------------------------------------------
  assign out_add_o  = in_add_i;
  assign out_wen_o  = {MP{in_wen_i}};
  assign out_be_o   = in_be_i;
  assign out_data_o = in_data_i;
  assign out_id_o   = in_id_i;

  // ---------------------------------------------------------------------------
  // Request issue. A port that already took its grant drops req until the
  // whole wide access is granted, so it is never issued twice.
  // ---------------------------------------------------------------------------
  assign w_issue_ok = ~rst_i & in_req_i & (r_cnt < CW'(R_DEPTH));
  assign out_req_o  = {MP{w_issue_ok}} & ~r_gnt_q;
  assign w_gnt_now  = out_gnt_i & out_req_o;
  assign w_all_g    = &(r_gnt_q | w_gnt_now);
  assign in_gnt_o   = w_issue_ok & w_all_g;

  // Responses are always accepted outside reset; buffer space is guaranteed
  // by the credit limit.
  assign out_r_ready_o = {MP{~rst_i}};

  // Remember which ports hold a grant for the access being assembled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gnt_q <= '0;
    end else if (in_gnt_o) begin
      r_gnt_q <= '0;
    end else begin
      r_gnt_q <= r_gnt_q | w_gnt_now;
    end
  end

  // Outstanding wide accesses: +1 on wide grant, -1 on assembled pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      case ({in_gnt_o, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response collection. A response is only buffered when its port has a
  // granted transaction without answer (possibly granted this very cycle);
  // anything else is a stray beat and is discarded.
  // ---------------------------------------------------------------------------
  // Decide per port whether the incoming response beat is buffered.
  always_comb begin
    w_push = '0;
    for (int i = 0; i < MP; i++) begin
      w_push[i] = ~rst_i & out_r_valid_i[i] &
                  ((r_p_cnt[i] != '0) | w_gnt_now[i]);
    end
  end

  // Per-port count of granted narrow transactions still awaiting a response.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      if (rst_i) begin
        r_p_cnt[i] <= '0;
      end else if (w_gnt_now[i] & ~w_push[i]) begin
        r_p_cnt[i] <= r_p_cnt[i] + PW'(1);
      end else if (~w_gnt_now[i] & w_push[i]) begin
        r_p_cnt[i] <= r_p_cnt[i] - PW'(1);
      end
    end
  end

  // One response FIFO per narrow port. Only port 0 keeps its ID unless the
  // error option needs every head ID for the consistency check.
  for (genvar g = 0; g < MP; g++) begin : g_port
    if (g < NID) begin : g_id
      logic [IDW+31:0] w_head;

      softex_tcdm_mp_sync_fifo #(
        .W     (IDW + 32),
        .DEPTH (R_DEPTH)
      ) i_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push[g]),
        .i_dat   ({out_r_id_i[g*IDW +: IDW], out_r_data_i[g*32 +: 32]}),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_empty (w_empty[g])
      );

      assign w_head_dat[g] = w_head[31:0];
      assign w_head_id[g]  = w_head[IDW+31:32];
    end else begin : g_dat
      softex_tcdm_mp_sync_fifo #(
        .W     (32),
        .DEPTH (R_DEPTH)
      ) i_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push[g]),
        .i_dat   (out_r_data_i[g*32 +: 32]),
        .i_pop   (w_pop),
        .o_dat   (w_head_dat[g]),
        .o_empty (w_empty[g])
      );
    end
  end

`ifndef SOFTEX_TCDM_MP_SYNC_ERR_EN
  // Response IDs of ports other than 0 carry no information in this build.
  if (MP > 1) begin : g_unused_id
    logic w_unused_ids;
    assign w_unused_ids = ^out_r_id_i[MP*IDW-1:IDW];
  end
`endif

  // ---------------------------------------------------------------------------
  // Response assembly: the wide response exists once every port FIFO holds
  // an entry; all FIFOs pop together.
  // ---------------------------------------------------------------------------
  // Combine per-port FIFO state into the assembled wide response.
  always_comb begin
    w_all_full  = 1'b1;
    in_r_data_o = '0;
    for (int i = 0; i < MP; i++) begin
      w_all_full = w_all_full & ~w_empty[i];
      in_r_data_o[i*32 +: 32] = w_head_dat[i];
    end
  end

  assign in_r_valid_o = ~rst_i & w_all_full;
  assign in_r_id_o    = w_head_id[0];
  assign w_pop        = in_r_valid_o & in_r_ready_i;

`ifdef SOFTEX_TCDM_MP_SYNC_ERR_EN
  // ---------------------------------------------------------------------------
  // Sticky error: stray response beats, or port heads that disagree on the ID
  // of the wide response being presented.
  // ---------------------------------------------------------------------------
  logic r_err;
  logic w_drop;
  logic w_id_mis;

  assign w_drop = ~rst_i & |(out_r_valid_i & ~w_push);

  // Compare every head ID against port 0 while a response is presented.
  always_comb begin
    w_id_mis = 1'b0;
    for (int i = 1; i < MP; i++) begin
      if (w_head_id[i] != w_head_id[0]) begin
        w_id_mis = 1'b1;
      end
    end
    w_id_mis = w_id_mis & in_r_valid_o;
  end

  // Latch any error until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_drop | w_id_mis) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

endmodule
